// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt request encoder.
//   N_REQ     : number of request lines
//   ID_W      : width of an encoded request index (log2 of N_REQ)
//   req_vec_t : one bit per request line
//   id_t      : encoded request index
//   state_t   : presentation FSM state
package irq_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = $clog2(N_REQ);

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [ID_W-1:0]  id_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // One-hot vector with only bit 'id' set.
  function automatic req_vec_t id_onehot(input id_t id);
    return req_vec_t'(1) << id;
  endfunction

endpackage

// File: rtl/irq_encoder_if.sv
// Valid/ready output channel carrying encoded request IDs.
//   id_o    : encoded index of the presented request
//   valid_o : id_o holds a presented request
//   ready_i : consumer accepts id_o this cycle when valid_o=1
// master = encoder side, slave = consumer side.
interface irq_encoder_if;
  import irq_pkg::*;

  id_t  id_o;
  logic valid_o;
  logic ready_i;

  modport master (
    output id_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  id_o,
    input  valid_o,
    output ready_i
  );

endinterface

// File: rtl/irq_encoder_prio_enc8.sv
// Combinational lowest-index-first priority encoder.
//   in  : candidate vector
//   idx : index of the lowest set bit (0 when nothing is set)
//   any : at least one bit of in is set
module prio_enc8
  import irq_pkg::*;
(
  input  req_vec_t in,
  output id_t      idx,
  output logic     any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    // Scan from the top down so the lowest set bit is the last to write idx.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (in[i]) begin
        idx = id_t'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_encoder.sv
// Sequential 8-to-3 interrupt encoder.
// Captures rising edges of the request lines into a pending register and
// presents the lowest-index unmasked pending request on a valid/ready channel,
// once per captured event.
//   clk        : clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   req_i      : request lines, level-sampled, edge-detected internally
//   mask_i     : 1 = bit excluded from selection (still kept pending)
//   clr_ovf_i  : clears the sticky overflow flag
//   bus        : id_o / valid_o / ready_i handshake (master side)
//   pending_o  : current pending register
//   overflow_o : sticky flag, an event arrived on an already-pending bit
module irq_encoder
  import irq_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  req_vec_t req_i,
  input  req_vec_t mask_i,
  input  logic     clr_ovf_i,
  irq_encoder_if.master bus,
  output req_vec_t pending_o,
  output logic     overflow_o
);

  state_t   state_reg;
  req_vec_t req_q_reg;
  req_vec_t pending_reg;
  logic     overflow_reg;
  id_t      id_reg;
  logic     valid_reg;

  req_vec_t rise;
  req_vec_t clr;
  req_vec_t cand;
  req_vec_t pending_next;
  logic     overflow_next;
  logic     accept;
  id_t      cand_idx;
  logic     cand_any;

  always_comb begin
    rise   = req_i & ~req_q_reg;
    accept = valid_reg & bus.ready_i;
    clr    = accept ? id_onehot(id_reg) : '0;
    // A new rise on the bit being accepted re-pends it (set beats clear).
    pending_next  = (pending_reg & ~clr) | rise;
    // An event is lost only if its bit is still pending after this cycle's clear.
    overflow_next = (|(rise & pending_reg & ~clr)) | (overflow_reg & ~clr_ovf_i);
    // The bit being accepted is excluded so back-to-back issue never repeats it.
    cand = pending_reg & ~mask_i & ~clr;
  end

  prio_enc8 u_prio_enc8 (
    .in  (cand),
    .idx (cand_idx),
    .any (cand_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      req_q_reg    <= '0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
      id_reg       <= '0;
      valid_reg    <= 1'b0;
    end else begin
      req_q_reg    <= req_i;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
      case (state_reg)
        IDLE: begin
          if (cand_any) begin
            id_reg    <= cand_idx;
            valid_reg <= 1'b1;
            state_reg <= PRESENT;
          end
        end
        PRESENT: begin
          // The presented ID is held until accepted, even if it gets masked
          // or a higher-priority request arrives meanwhile.
          if (bus.ready_i) begin
            if (cand_any) begin
              id_reg <= cand_idx;
            end else begin
              valid_reg <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.id_o    = id_reg;
  assign bus.valid_o = valid_reg;
  assign pending_o   = pending_reg;
  assign overflow_o  = overflow_reg;

endmodule

// File: tb/tb_irq_encoder.sv
// Self-checking bench for irq_encoder: directed vector table, hand-written
// multi-cycle sequences, then random stimulus against a behavioural model.
module tb_irq_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_i;
  logic [7:0] mask_i;
  logic       clr_ovf_i;
  logic [7:0] pending_o;
  logic       overflow_o;

  irq_encoder_if bus();

  irq_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .mask_i     (mask_i),
    .clr_ovf_i  (clr_ovf_i),
    .bus        (bus),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       ready;
    logic       clr_ovf;
    logic       exp_valid;
    logic [2:0] exp_id;
    logic [7:0] exp_pend;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] r, input logic [7:0] m, input logic rdy, input logic co,
                     input logic v, input logic [2:0] id, input logic [7:0] p, input logic o);
    vec_t e;
    e.req = r; e.mask = m; e.ready = rdy; e.clr_ovf = co;
    e.exp_valid = v; e.exp_id = id; e.exp_pend = p; e.exp_ovf = o;
    tbl.push_back(e);
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_valid;
  int m_id;
  bit m_pend[8];
  bit m_prev[8];
  bit m_ovf;

  task automatic model_reset();
    m_valid = 0;
    m_id    = 0;
    m_ovf   = 0;
    for (int b = 0; b < 8; b++) begin
      m_pend[b] = 0;
      m_prev[b] = 0;
    end
  endtask

  // Applies one clock edge given the inputs seen at that edge.
  task automatic model_step(input logic [7:0] r, input logic [7:0] mk, input logic rdy, input logic co);
    bit acc;
    bit hit;
    bit newp[8];
    int nxt;
    acc = m_valid && rdy;
    hit = 0;
    for (int b = 0; b < 8; b++) begin
      bit taken;
      bit rising;
      taken  = acc && (b == m_id);
      rising = r[b] && !m_prev[b];
      if (rising && m_pend[b] && !taken) hit = 1;
      newp[b] = (m_pend[b] && !taken) || rising;
    end
    if (!m_valid || acc) begin
      nxt = -1;
      for (int b = 0; b < 8; b++)
        if (nxt < 0 && m_pend[b] && !mk[b] && !(acc && b == m_id)) nxt = b;
      m_valid = (nxt >= 0);
      if (nxt >= 0) m_id = nxt;
    end
    if (hit) m_ovf = 1;
    else if (co) m_ovf = 0;
    for (int b = 0; b < 8; b++) begin
      m_pend[b] = newp[b];
      m_prev[b] = r[b];
    end
  endtask

  function automatic logic [7:0] model_pend_vec();
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = m_pend[b];
    return v;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    int hold_cnt;
    logic [2:0] hold_id;

    rst_n = 1'b0; req_i = '0; mask_i = '0; clr_ovf_i = 1'b0; bus.ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset valid", bus.valid_o, 0);
    chk("reset id", bus.id_o, 0);
    chk("reset pending", pending_o, 0);
    chk("reset overflow", overflow_o, 0);
    $display("reset released: valid=%0d id=%0d pending=%02h ovf=%0d", bus.valid_o, bus.id_o, pending_o, overflow_o);

    // single pulse on bit 4, stall for five cycles, then accept
    add(8'h10, 8'h00, 0, 0, 0, 0, 8'h10, 0);
    add(8'h00, 8'h00, 0, 0, 1, 4, 8'h10, 0);
    for (int i = 0; i < 5; i++) add(8'h00, 8'h00, 0, 0, 1, 4, 8'h10, 0);
    add(8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0);
    // A5 burst with ready held: 0,2,5,7 back to back
    add(8'hA5, 8'h00, 1, 0, 0, 0, 8'hA5, 0);
    add(8'h00, 8'h00, 1, 0, 1, 0, 8'hA5, 0);
    add(8'h00, 8'h00, 1, 0, 1, 2, 8'hA4, 0);
    add(8'h00, 8'h00, 1, 0, 1, 5, 8'hA0, 0);
    add(8'h00, 8'h00, 1, 0, 1, 7, 8'h80, 0);
    add(8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0);
    // masked bit 0 stays pending, issued once unmasked
    add(8'h03, 8'h01, 1, 0, 0, 0, 8'h03, 0);
    add(8'h00, 8'h01, 1, 0, 1, 1, 8'h03, 0);
    add(8'h00, 8'h01, 1, 0, 0, 0, 8'h01, 0);
    add(8'h00, 8'h01, 1, 0, 0, 0, 8'h01, 0);
    add(8'h00, 8'h00, 0, 0, 1, 0, 8'h01, 0);
    add(8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0);
    // overflow on bit 3 while stalled, single issue, then clear
    add(8'h08, 8'h00, 0, 0, 0, 0, 8'h08, 0);
    add(8'h00, 8'h00, 0, 0, 1, 3, 8'h08, 0);
    add(8'h08, 8'h00, 0, 0, 1, 3, 8'h08, 1);
    add(8'h00, 8'h00, 0, 0, 1, 3, 8'h08, 1);
    add(8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 1);
    add(8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 0);
    // overflow set wins over simultaneous clear
    add(8'h08, 8'h00, 0, 0, 0, 0, 8'h08, 0);
    add(8'h00, 8'h00, 0, 0, 1, 3, 8'h08, 0);
    add(8'h08, 8'h00, 0, 1, 1, 3, 8'h08, 1);
    add(8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 0);
    // rise on the bit being accepted re-pends it, no overflow
    add(8'h08, 8'h00, 0, 0, 0, 0, 8'h08, 0);
    add(8'h00, 8'h00, 0, 0, 1, 3, 8'h08, 0);
    add(8'h08, 8'h00, 1, 0, 0, 0, 8'h08, 0);
    add(8'h00, 8'h00, 0, 0, 1, 3, 8'h08, 0);
    add(8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0);
    // presented ID not replaced by higher-priority arrival nor by masking
    add(8'h04, 8'h00, 0, 0, 0, 0, 8'h04, 0);
    add(8'h00, 8'h00, 0, 0, 1, 2, 8'h04, 0);
    add(8'h01, 8'h00, 0, 0, 1, 2, 8'h05, 0);
    add(8'h00, 8'h04, 0, 0, 1, 2, 8'h05, 0);
    add(8'h00, 8'h00, 1, 0, 1, 0, 8'h01, 0);
    add(8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      req_i = tbl[i].req; mask_i = tbl[i].mask;
      bus.ready_i = tbl[i].ready; clr_ovf_i = tbl[i].clr_ovf;
      tick();
      chk($sformatf("vec%0d valid", i), bus.valid_o, tbl[i].exp_valid);
      chk($sformatf("vec%0d pending", i), pending_o, tbl[i].exp_pend);
      chk($sformatf("vec%0d overflow", i), overflow_o, tbl[i].exp_ovf);
      if (tbl[i].exp_valid) chk($sformatf("vec%0d id", i), bus.id_o, tbl[i].exp_id);
      $display("vec%0d req=%02h mask=%02h rdy=%0d -> valid=%0d id=%0d pend=%02h ovf=%0d",
               i, tbl[i].req, tbl[i].mask, tbl[i].ready, bus.valid_o, bus.id_o, pending_o, overflow_o);
    end

    // held-high bit 2 produces exactly one ID
    req_i = 8'h04; mask_i = '0; bus.ready_i = 1'b1; clr_ovf_i = 1'b0;
    hold_cnt = 0; hold_id = '0;
    for (int i = 0; i < 23; i++) begin
      if (i == 20) req_i = 8'h00;
      tick();
      if (bus.valid_o) begin
        hold_cnt++;
        hold_id = bus.id_o;
      end
    end
    chk("held-high issue count", hold_cnt, 1);
    chk("held-high id", hold_id, 2);
    chk("held-high pending", pending_o, 0);
    $display("held-high: %0d issue(s), id=%0d", hold_cnt, hold_id);

    // reset in the middle of a stall
    bus.ready_i = 1'b0;
    req_i = 8'h0F; tick();
    req_i = 8'h00; tick();
    req_i = 8'h0F; tick();
    chk("pre-reset valid", bus.valid_o, 1);
    chk("pre-reset pending", pending_o, 8'h0F);
    chk("pre-reset overflow", overflow_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", bus.valid_o, 0);
    chk("async reset id", bus.id_o, 0);
    chk("async reset pending", pending_o, 0);
    chk("async reset overflow", overflow_o, 0);
    $display("mid-stall reset: valid=%0d id=%0d pend=%02h ovf=%0d", bus.valid_o, bus.id_o, pending_o, overflow_o);
    req_i = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post-reset valid c%0d", i), bus.valid_o, 0);
      chk($sformatf("post-reset pending c%0d", i), pending_o, 0);
    end

    // random stimulus against the model, starting from a fresh reset
    rst_n = 1'b0; req_i = '0; mask_i = '0; bus.ready_i = 1'b0; clr_ovf_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req_i = 8'($urandom);
      mask_i      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      bus.ready_i = ($urandom_range(0, 2) != 0);
      clr_ovf_i   = ($urandom_range(0, 15) == 0);
      if (bus.valid_o && bus.ready_i)
        $display("rnd c%0d accept id=%0d pend=%02h", c, bus.id_o, pending_o);
      model_step(req_i, mask_i, bus.ready_i, clr_ovf_i);
      tick();
      chk($sformatf("rnd c%0d valid", c), bus.valid_o, m_valid);
      chk($sformatf("rnd c%0d pending", c), pending_o, model_pend_vec());
      chk($sformatf("rnd c%0d overflow", c), overflow_o, m_ovf);
      if (m_valid) chk($sformatf("rnd c%0d id", c), bus.id_o, m_id);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
